qmult_arbiter: RTL and testbench

QMULT_ARBITER -- requirements
Module: qmult_arbiter

---
 rtl/qmult_arbiter.sv | 126 ++++++++++++
 tb/tb_qmult_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmult_arbiter.sv
// Round-robin arbiter that shares one sign-magnitude (N,Q) fixed-point multiplier among NREQ requesters.
// Optional build macro QMULT_ARB_SAT_EN saturates overflowing magnitudes instead of truncating them.
module qmult_arbiter #(
    parameter int N    = 32,
    parameter int Q    = 15,
    parameter int NREQ = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*N-1:0]       i_req_a,
    input  logic [NREQ*N-1:0]       i_req_b,
    output logic [NREQ-1:0]         o_req_ready,
    output logic                    o_rsp_valid,
    output logic [$clog2(NREQ)-1:0] o_rsp_id,
    output logic [N-1:0]            o_rsp_result,
    output logic                    o_rsp_ovr,
    input  logic                    i_rsp_ready
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t        state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] id_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          rsp_valid_q;
    logic [IW-1:0] rsp_id_q;
    logic [N-1:0]  result_q;
    logic          ovr_q;

    logic          grant_found;
    logic [IW-1:0] grant_idx;
    logic [NREQ-1:0] grant_vec;

    logic [2*N-1:0] prod;
    logic           prod_ovr;
    logic [N-2:0]   prod_mag;
    logic           prod_unused;

    // Two passes, lowest index wins in each: the second pass (indices at or above the
    // pointer) overrides the first, which gives a wrapping search starting at ptr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (i < int'(ptr_q))) begin
                grant_found = 1'b1;
                grant_idx   = IW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req_valid[i] && (i >= int'(ptr_q))) begin
                grant_found = 1'b1;
                grant_idx   = IW'(i);
            end
        end
        grant_vec = '0;
        if (grant_found) begin
            grant_vec[grant_idx] = 1'b1;
        end
        ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    assign o_req_ready = ((state_q == S_IDLE) && i_rst_n) ? grant_vec : '0;

    assign prod        = {{(N+1){1'b0}}, a_q[N-2:0]} * {{(N+1){1'b0}}, b_q[N-2:0]};
    assign prod_ovr    = |prod[2*N-2:N-1+Q];
    assign prod_unused = ^{prod[2*N-1], prod[Q-1:0]};

`ifdef QMULT_ARB_SAT_EN
    assign prod_mag = prod_ovr ? '1 : prod[N-2+Q:Q];
`else
    assign prod_mag = prod[N-2+Q:Q];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            result_q    <= '0;
            ovr_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        a_q     <= i_req_a[grant_idx*N +: N];
                        b_q     <= i_req_b[grant_idx*N +: N];
                        id_q    <= grant_idx;
                        ptr_q   <= ptr_d;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    result_q    <= {a_q[N-1] ^ b_q[N-1], prod_mag};
                    ovr_q       <= prod_ovr;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = result_q;
    assign o_rsp_ovr    = ovr_q;

endmodule

// File: tb/tb_qmult_arbiter.sv
// Self-checking bench for qmult_arbiter: directed vectors plus randomized traffic against a
// round-robin / fixed-point arithmetic reference model.
module tb_qmult_arbiter;

    localparam int N    = 32;
    localparam int Q    = 15;
    localparam int NREQ = 4;
    localparam int IW   = $clog2(NREQ);

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ*N-1:0] i_req_a;
    logic [NREQ*N-1:0] i_req_b;
    logic [NREQ-1:0]   o_req_ready;
    logic              o_rsp_valid;
    logic [IW-1:0]     o_rsp_id;
    logic [N-1:0]      o_rsp_result;
    logic              o_rsp_ovr;
    logic              i_rsp_ready;

    int errors    = 0;
    int checks    = 0;
    int model_ptr = 0;

    qmult_arbiter #(.N(N), .Q(Q), .NREQ(NREQ)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .i_req_a      (i_req_a),
        .i_req_b      (i_req_b),
        .o_req_ready  (o_req_ready),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_result (o_rsp_result),
        .o_rsp_ovr    (o_rsp_ovr),
        .i_rsp_ready  (i_rsp_ready)
    );

    always #5 i_clk = ~i_clk;

    // Reference: first valid requester at or after the pointer, wrapping around.
    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (ptr + i) % NREQ;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // Reference: real-valued product of magnitudes scaled by 2^-Q, then fitted into N-1 bits.
    function automatic void model_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                      output logic [N-1:0] res, output logic ovr);
        logic [63:0] ma, mb, s;
        logic [N-2:0] mag;
        ma  = 64'(a[N-2:0]);
        mb  = 64'(b[N-2:0]);
        s   = (ma * mb) >> Q;
        ovr = (s >> (N - 1)) != 64'd0;
        mag = s[N-2:0];
`ifdef QMULT_ARB_SAT_EN
        if (ovr) mag = '1;
`endif
        res = {a[N-1] ^ b[N-1], mag};
    endfunction

    function automatic logic [N-1:0] rand_operand();
        logic [31:0] r;
        r     = $urandom >> $urandom_range(1, 31);
        r[31] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Drives one request set until a grant, then follows the granted operation to completion.
    // Enter and leave shortly after a falling edge. Observations only; callers compare.
    task automatic run_txn(input logic [NREQ-1:0] mask, input logic [NREQ*N-1:0] av,
                           input logic [NREQ*N-1:0] bv, input int hold,
                           output logic [NREQ-1:0] gnt, output logic [IW-1:0] id,
                           output logic [N-1:0] res, output logic ovr,
                           output bit lat_ok, output bit hold_ok, output bit done_ok);
        i_req_valid = mask;
        i_req_a     = av;
        i_req_b     = bv;
        i_rsp_ready = (hold == 0);
        gnt = '0; id = '0; res = '0; ovr = 1'b0;
        lat_ok = 1'b0; hold_ok = 1'b1; done_ok = 1'b0;
        #1;
        for (int t = 0; t < 8 && o_req_ready == '0; t++) begin
            @(negedge i_clk); #1;
        end
        gnt = o_req_ready;
        if (gnt == '0) begin
            i_req_valid = '0;
            i_rsp_ready = 1'b1;
            return;
        end
        @(posedge i_clk); #1;
        i_req_valid = i_req_valid & ~gnt;
        @(negedge i_clk); #1;
        lat_ok = (o_rsp_valid === 1'b0) && (o_req_ready === '0);
        @(negedge i_clk); #1;
        lat_ok = lat_ok && (o_rsp_valid === 1'b1) && (o_req_ready === '0);
        id  = o_rsp_id;
        res = o_rsp_result;
        ovr = o_rsp_ovr;
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk); #1;
            if (!(o_rsp_valid === 1'b1 && o_rsp_id === id && o_rsp_result === res &&
                  o_rsp_ovr === ovr && o_req_ready === '0))
                hold_ok = 1'b0;
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk); #1;
        done_ok     = (o_rsp_valid === 1'b0);
        i_req_valid = '0;
    endtask

    task automatic test_reset();
        i_rst_n     = 1'b0;
        i_rsp_ready = 1'b1;
        i_req_valid = '1;
        for (int k = 0; k < NREQ; k++) begin
            i_req_a[k*N +: N] = rand_operand();
            i_req_b[k*N +: N] = rand_operand();
        end
        repeat (2) @(negedge i_clk);
        #1;
        checks++; if (o_req_ready !== '0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", o_req_ready); end
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_rsp_valid); end
        checks++; if (o_rsp_id !== '0) begin errors++; $display("[TB] FAIL reset_id: got %0d expected 0", o_rsp_id); end
        checks++; if (o_rsp_result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", o_rsp_result); end
        checks++; if (o_rsp_ovr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovr: got %b expected 0", o_rsp_ovr); end
        @(negedge i_clk);
        i_req_valid = '0;
        i_rst_n     = 1'b1;
        model_ptr   = 0;
        #1;
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_valid: got %b expected 0", o_rsp_valid); end
    endtask

    task automatic test_directed();
        int          req  [3] = '{0, 2, 1};
        logic [N-1:0] va  [3] = '{32'h0000_8000, 32'h0000_4000, 32'h4000_0000};
        logic [N-1:0] vb  [3] = '{32'h0000_8000, 32'h8000_4000, 32'h4000_0000};
`ifdef QMULT_ARB_SAT_EN
        logic [N-1:0] vr  [3] = '{32'h0000_8000, 32'h8000_2000, 32'h7FFF_FFFF};
`else
        logic [N-1:0] vr  [3] = '{32'h0000_8000, 32'h8000_2000, 32'h0000_0000};
`endif
        logic         vo  [3] = '{1'b0, 1'b0, 1'b1};
        logic [NREQ-1:0] gnt, exp_g;
        logic [IW-1:0]   id;
        logic [N-1:0]    res;
        logic            ovr;
        bit              lat_ok, hold_ok, done_ok;
        logic [NREQ*N-1:0] av, bv;
        for (int t = 0; t < 3; t++) begin
            av = '0; bv = '0;
            av[req[t]*N +: N] = va[t];
            bv[req[t]*N +: N] = vb[t];
            exp_g = '0; exp_g[req[t]] = 1'b1;
            run_txn(exp_g, av, bv, 0, gnt, id, res, ovr, lat_ok, hold_ok, done_ok);
            model_ptr = (req[t] + 1) % NREQ;
            checks++; if (gnt !== exp_g) begin errors++; $display("[TB] FAIL dir_grant[%0d]: got %b expected %b", t, gnt, exp_g); end
            checks++; if (id !== IW'(req[t])) begin errors++; $display("[TB] FAIL dir_id[%0d]: got %0d expected %0d", t, id, req[t]); end
            checks++; if (res !== vr[t]) begin errors++; $display("[TB] FAIL dir_result[%0d]: got %h expected %h", t, res, vr[t]); end
            checks++; if (ovr !== vo[t]) begin errors++; $display("[TB] FAIL dir_ovr[%0d]: got %b expected %b", t, ovr, vo[t]); end
            checks++; if (lat_ok !== 1'b1) begin errors++; $display("[TB] FAIL dir_latency[%0d]: got %b expected 1", t, lat_ok); end
            checks++; if (done_ok !== 1'b1) begin errors++; $display("[TB] FAIL dir_release[%0d]: got %b expected 1", t, done_ok); end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask, gnt, exp_g;
        logic [IW-1:0]   id;
        logic [N-1:0]    res, exp_r;
        logic            ovr, exp_o;
        bit              lat_ok, hold_ok, done_ok;
        logic [NREQ*N-1:0] av, bv;
        int k, hold;
        for (int it = 0; it < 24; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int j = 0; j < NREQ; j++) begin
                av[j*N +: N] = rand_operand();
                bv[j*N +: N] = rand_operand();
            end
            hold = $urandom_range(0, 2);
            k = rr_pick(model_ptr, mask);
            model_ptr = (k + 1) % NREQ;
            exp_g = '0; exp_g[k] = 1'b1;
            model_mul(av[k*N +: N], bv[k*N +: N], exp_r, exp_o);
            run_txn(mask, av, bv, hold, gnt, id, res, ovr, lat_ok, hold_ok, done_ok);
            checks++; if (gnt !== exp_g) begin errors++; $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", it, gnt, exp_g); end
            checks++; if (id !== IW'(k)) begin errors++; $display("[TB] FAIL rand_id[%0d]: got %0d expected %0d", it, id, k); end
            checks++; if (res !== exp_r) begin errors++; $display("[TB] FAIL rand_result[%0d]: got %h expected %h", it, res, exp_r); end
            checks++; if (ovr !== exp_o) begin errors++; $display("[TB] FAIL rand_ovr[%0d]: got %b expected %b", it, ovr, exp_o); end
            checks++; if ({lat_ok, hold_ok, done_ok} !== 3'b111) begin errors++; $display("[TB] FAIL rand_timing[%0d]: got %b expected 111", it, {lat_ok, hold_ok, done_ok}); end
        end
    endtask

    task automatic test_hold();
        logic [NREQ-1:0] gnt, exp_g;
        logic [IW-1:0]   id;
        logic [N-1:0]    res, exp_r;
        logic            ovr, exp_o;
        bit              lat_ok, hold_ok, done_ok;
        logic [NREQ*N-1:0] av, bv;
        int k;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < NREQ; j++) begin
                av[j*N +: N] = rand_operand();
                bv[j*N +: N] = rand_operand();
            end
            k = rr_pick(model_ptr, '1);
            model_ptr = (k + 1) % NREQ;
            exp_g = '0; exp_g[k] = 1'b1;
            model_mul(av[k*N +: N], bv[k*N +: N], exp_r, exp_o);
            run_txn('1, av, bv, (pass == 0) ? 5 : 0, gnt, id, res, ovr, lat_ok, hold_ok, done_ok);
            checks++; if (gnt !== exp_g) begin errors++; $display("[TB] FAIL hold_grant[%0d]: got %b expected %b", pass, gnt, exp_g); end
            checks++; if (res !== exp_r || ovr !== exp_o) begin errors++; $display("[TB] FAIL hold_result[%0d]: got %h/%b expected %h/%b", pass, res, ovr, exp_r, exp_o); end
            checks++; if (hold_ok !== 1'b1) begin errors++; $display("[TB] FAIL hold_stable[%0d]: got %b expected 1", pass, hold_ok); end
            checks++; if (done_ok !== 1'b1) begin errors++; $display("[TB] FAIL hold_release[%0d]: got %b expected 1", pass, done_ok); end
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] gnt;
        logic [IW-1:0]   id;
        logic [N-1:0]    res;
        logic            ovr;
        bit              lat_ok, hold_ok, done_ok;
        logic [NREQ*N-1:0] av, bv;
        for (int j = 0; j < NREQ; j++) begin
            av[j*N +: N] = rand_operand();
            bv[j*N +: N] = rand_operand();
        end
        i_req_valid = 4'b0100;
        i_req_a     = av;
        i_req_b     = bv;
        i_rsp_ready = 1'b1;
        #1;
        checks++; if (o_req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL rmid_grant: got %b expected 0100", o_req_ready); end
        @(posedge i_clk); #1;
        i_req_valid = '1;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_req_ready !== '0) begin errors++; $display("[TB] FAIL rmid_ready: got %b expected 0", o_req_ready); end
        checks++; if ({o_rsp_valid, o_rsp_ovr} !== 2'b00) begin errors++; $display("[TB] FAIL rmid_flags: got %b expected 00", {o_rsp_valid, o_rsp_ovr}); end
        checks++; if (o_rsp_id !== '0 || o_rsp_result !== '0) begin errors++; $display("[TB] FAIL rmid_data: got %0d/%h expected 0/0", o_rsp_id, o_rsp_result); end
        @(negedge i_clk);
        i_req_valid = 4'b1001;
        i_rst_n     = 1'b1;
        model_ptr   = 0;
        #1;
        checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_next_grant: got %b expected 0001", o_req_ready); end
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_no_rsp: got %b expected 0", o_rsp_valid); end
        i_req_valid = '0;
        run_txn(4'b1001, av, bv, 0, gnt, id, res, ovr, lat_ok, hold_ok, done_ok);
        model_ptr = 1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_after_grant: got %b expected 0001", gnt); end
        checks++; if (lat_ok !== 1'b1) begin errors++; $display("[TB] FAIL rmid_after_latency: got %b expected 1", lat_ok); end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] exp_g;
        logic            exp_v;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        for (int j = 0; j < NREQ; j++) begin
            i_req_a[j*N +: N] = rand_operand();
            i_req_b[j*N +: N] = rand_operand();
        end
        i_req_valid = '1;
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) begin
            exp_g = '0;
            if (i % 3 == 0) exp_g[(i / 3) % NREQ] = 1'b1;
            exp_v = (i % 3 == 2);
            checks++; if (o_req_ready !== exp_g) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", i, o_req_ready, exp_g); end
            checks++; if (o_rsp_valid !== exp_v) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", i, o_rsp_valid, exp_v); end
            @(negedge i_clk); #1;
        end
        i_req_valid = '0;
    endtask

    initial begin
        $display("[TB] qmult_arbiter bench start");
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        i_rsp_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
